// File: rtl/regfile_scan_reader.sv
// Sequential reader for a 2**AW x DW register file: walks a contiguous address run and
// streams each word over valid/ready, flagging words overwritten while they wait.
module regfile_scan_reader #(
    parameter int AW    = 5,
    parameter int DW    = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AW-1:0]    start_addr,
    input  logic [CNT_W-1:0] count,
    input  logic             abort,
    output logic [AW-1:0]    rf_ra,
    input  logic [DW-1:0]    rf_rd,
    input  logic             wb_we,
    input  logic [AW-1:0]    wb_wa,
    output logic [DW-1:0]    dout,
    output logic [AW-1:0]    dout_addr,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             dout_stale,
    output logic             busy,
    output logic             done
);

    // state | meaning
    // IDLE  | waiting for start; rf_ra parked at last address
    // READ  | rf_rd valid for rf_ra this cycle; capture into dout
    // HOLD  | word presented on dout, waiting for consumer accept

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(2 ** AW);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(1);

    state_t           state;
    logic [AW-1:0]    addr;
    logic [CNT_W-1:0] remaining;

    logic [AW-1:0]    next_addr;
    logic [CNT_W-1:0] clamped_count;
    logic             wb_hit;
    logic             accept;

    assign next_addr     = addr + 1'b1;
    assign clamped_count = (count > MAX_CNT) ? MAX_CNT : count;
    // Register 0 is hard-wired, so a write to it can never change the held word.
    assign wb_hit        = wb_we && (wb_wa == dout_addr) && (wb_wa != '0);
    assign accept        = dout_valid && dout_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            addr       <= '0;
            remaining  <= '0;
            rf_ra      <= '0;
            dout       <= '0;
            dout_addr  <= '0;
            dout_valid <= 1'b0;
            dout_stale <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && (state != IDLE)) begin
                state      <= IDLE;
                dout_valid <= 1'b0;
                dout_stale <= 1'b0;
                busy       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort && (count != '0)) begin
                            addr      <= start_addr;
                            remaining <= clamped_count;
                            rf_ra     <= start_addr;
                            busy      <= 1'b1;
                            state     <= READ;
                        end
                    end
                    READ: begin
                        // A write landing this cycle is already visible on rf_rd.
                        dout       <= rf_rd;
                        dout_addr  <= rf_ra;
                        dout_valid <= 1'b1;
                        dout_stale <= 1'b0;
                        state      <= HOLD;
                    end
                    HOLD: begin
                        if (accept) begin
                            dout_valid <= 1'b0;
                            dout_stale <= 1'b0;
                            remaining  <= remaining - LAST;
                            if (remaining == LAST) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end else begin
                                addr  <= next_addr;
                                rf_ra <= next_addr;
                                state <= READ;
                            end
                        end else if (wb_hit) begin
                            dout_stale <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_regfile_scan_reader.sv
// Directed bench for regfile_scan_reader with a negedge-write register-file model.
module tb_regfile_scan_reader;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int CNT_W = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [AW-1:0]    start_addr;
    logic [CNT_W-1:0] count;
    logic             abort;
    logic [AW-1:0]    rf_ra;
    logic [DW-1:0]    rf_rd;
    logic             wb_we;
    logic [AW-1:0]    wb_wa;
    logic [DW-1:0]    wb_wd;
    logic [DW-1:0]    dout;
    logic [AW-1:0]    dout_addr;
    logic             dout_valid;
    logic             dout_ready;
    logic             dout_stale;
    logic             busy;
    logic             done;

    logic [DW-1:0] regs   [32];
    logic [DW-1:0] shadow [32];

    int vectors     = 0;
    int miscompares = 0;

    regfile_scan_reader #(.AW(AW), .DW(DW), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .count      (count),
        .abort      (abort),
        .rf_ra      (rf_ra),
        .rf_rd      (rf_rd),
        .wb_we      (wb_we),
        .wb_wa      (wb_wa),
        .dout       (dout),
        .dout_addr  (dout_addr),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_stale (dout_stale),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Register file: writes on negedge, r0 reads as zero.
    always @(negedge clk) if (wb_we && (wb_wa != '0)) regs[wb_wa] <= wb_wd;
    assign rf_rd = (rf_ra == '0) ? '0 : regs[rf_ra];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rf_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wb_we = 1'b1;
        wb_wa = a;
        wb_wd = d;
        if (a != '0) shadow[a] = d;
        tick();
        wb_we = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rf_ra"}, DW'(rf_ra), 0);
        chk({tag, "_dout"}, dout, 0);
        chk({tag, "_dout_addr"}, DW'(dout_addr), 0);
        chk({tag, "_valid"}, DW'(dout_valid), 0);
        chk({tag, "_stale"}, DW'(dout_stale), 0);
        chk({tag, "_busy"}, DW'(busy), 0);
        chk({tag, "_done"}, DW'(done), 0);
    endtask

    // Full scan with ready held high: word every 2 cycles, done after last accept.
    task automatic run_scan(input logic [AW-1:0] sa, input logic [CNT_W-1:0] cnt, input int nwords);
        logic [AW-1:0] a;
        logic [AW-1:0] na;
        logic [DW-1:0] expd;
        start      = 1'b1;
        start_addr = sa;
        count      = cnt;
        dout_ready = 1'b1;
        tick();
        start = 1'b0;
        chk("lat_valid_lo", DW'(dout_valid), 0);
        chk("lat_busy", DW'(busy), 1);
        tick();
        for (int i = 0; i < nwords; i++) begin
            a    = sa + AW'(i);
            na   = a + 1'b1;
            expd = (a == '0) ? '0 : shadow[a];
            chk("w_valid", DW'(dout_valid), 1);
            chk("w_addr", DW'(dout_addr), DW'(a));
            chk("w_data", dout, expd);
            chk("w_stale", DW'(dout_stale), 0);
            tick();
            chk("acc_valid", DW'(dout_valid), 0);
            if (i == nwords - 1) begin
                chk("last_done", DW'(done), 1);
                chk("last_busy", DW'(busy), 0);
            end else begin
                chk("mid_done", DW'(done), 0);
                chk("next_ra", DW'(rf_ra), DW'(na));
                tick();
            end
        end
        tick();
        chk("done_pulse", DW'(done), 0);
        chk("end_valid", DW'(dout_valid), 0);
        chk("end_busy", DW'(busy), 0);
        dout_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        start_addr = '0;
        count      = '0;
        abort      = 1'b0;
        wb_we      = 1'b0;
        wb_wa      = '0;
        wb_wd      = '0;
        dout_ready = 1'b0;
        shadow[0]  = '0;
        #1 rst = 1'b1;
        #1;
        chk_all_zero("reset");
        tick();
        tick();
        rst = 1'b0;

        for (int a = 1; a < 32; a++) rf_write(AW'(a), 32'hA500_0000 + DW'(a));
        rf_write(5'd1, 32'd11);
        rf_write(5'd2, 32'd22);
        rf_write(5'd3, 32'd33);
        rf_write(5'd4, 32'd44);

        // Basic four-word scan, then wrap through r0.
        run_scan(5'd1, 6'd4, 4);
        run_scan(5'd30, 6'd4, 4);

        // Back-pressure: word held stable while ready is low.
        start = 1'b1; start_addr = 5'd3; count = 6'd1; dout_ready = 1'b0;
        tick();
        start = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", DW'(dout_valid), 1);
            chk("bp_dout", dout, 32'd33);
            chk("bp_addr", DW'(dout_addr), 3);
            tick();
        end
        dout_ready = 1'b1;
        tick();
        chk("bp_acc_valid", DW'(dout_valid), 0);
        chk("bp_done", DW'(done), 1);
        chk("bp_busy", DW'(busy), 0);
        dout_ready = 1'b0;
        tick();
        chk("bp_done_clr", DW'(done), 0);

        // Overwrite of held r5 marks it stale until accepted.
        start = 1'b1; start_addr = 5'd5; count = 6'd1;
        tick();
        start = 1'b0;
        tick();
        chk("st_dout", dout, 32'hA500_0005);
        chk("st_clean", DW'(dout_stale), 0);
        rf_write(5'd5, 32'd77);
        chk("st_set", DW'(dout_stale), 1);
        tick();
        chk("st_sticky", DW'(dout_stale), 1);
        chk("st_dout_held", dout, 32'hA500_0005);
        dout_ready = 1'b1;
        tick();
        chk("st_acc_stale", DW'(dout_stale), 0);
        chk("st_acc_done", DW'(done), 1);
        dout_ready = 1'b0;
        tick();

        // Writes to r0 or another register leave the held r5 clean.
        start = 1'b1; start_addr = 5'd5; count = 6'd1;
        tick();
        start = 1'b0;
        tick();
        chk("ns_dout", dout, 32'd77);
        rf_write(5'd0, 32'd99);
        chk("ns_r0", DW'(dout_stale), 0);
        rf_write(5'd6, 32'd66);
        chk("ns_r6", DW'(dout_stale), 0);
        dout_ready = 1'b1;
        tick();
        chk("ns_done", DW'(done), 1);
        dout_ready = 1'b0;
        tick();

        // Write in the READ cycle is captured, not flagged.
        start = 1'b1; start_addr = 5'd6; count = 6'd1;
        tick();
        start = 1'b0;
        wb_we = 1'b1; wb_wa = 5'd6; wb_wd = 32'd88; shadow[6] = 32'd88;
        tick();
        wb_we = 1'b0;
        chk("rd_dout", dout, 32'd88);
        chk("rd_stale", DW'(dout_stale), 0);
        tick();
        chk("rd_stale2", DW'(dout_stale), 0);
        dout_ready = 1'b1;
        tick();
        chk("rd_done", DW'(done), 1);
        dout_ready = 1'b0;
        tick();

        // Full-file and clamped scans.
        run_scan(5'd0, 6'd32, 32);
        run_scan(5'd7, 6'd40, 32);

        // count of zero is ignored.
        start = 1'b1; start_addr = 5'd2; count = 6'd0;
        tick();
        start = 1'b0;
        chk("c0_busy", DW'(busy), 0);
        tick();
        chk("c0_busy2", DW'(busy), 0);
        chk("c0_valid", DW'(dout_valid), 0);
        chk("c0_done", DW'(done), 0);

        // start while busy has no effect.
        start = 1'b1; start_addr = 5'd1; count = 6'd2; dout_ready = 1'b0;
        tick();
        start_addr = 5'd20; count = 6'd1;
        tick();
        chk("sb_valid", DW'(dout_valid), 1);
        chk("sb_addr", DW'(dout_addr), 1);
        tick();
        chk("sb_addr_held", DW'(dout_addr), 1);
        start = 1'b0;
        dout_ready = 1'b1;
        tick();
        chk("sb_ra", DW'(rf_ra), 2);
        chk("sb_no_done", DW'(done), 0);
        tick();
        chk("sb_addr2", DW'(dout_addr), 2);
        chk("sb_dout2", dout, 32'd22);
        tick();
        chk("sb_done", DW'(done), 1);
        dout_ready = 1'b0;
        tick();
        chk("sb_idle", DW'(busy), 0);

        // Abort on the second word, with ready high in the same cycle.
        start = 1'b1; start_addr = 5'd1; count = 6'd4; dout_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("ab_addr", DW'(dout_addr), 2);
        chk("ab_valid", DW'(dout_valid), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_busy", DW'(busy), 0);
        chk("ab_valid_lo", DW'(dout_valid), 0);
        chk("ab_stale", DW'(dout_stale), 0);
        chk("ab_done", DW'(done), 0);
        tick();
        chk("ab_done2", DW'(done), 0);
        chk("ab_busy2", DW'(busy), 0);
        dout_ready = 1'b0;

        // abort beats start in IDLE.
        start = 1'b1; abort = 1'b1; start_addr = 5'd1; count = 6'd2;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("as_busy", DW'(busy), 0);
        tick();
        chk("as_valid", DW'(dout_valid), 0);

        // Asynchronous reset in the middle of a scan.
        start = 1'b1; start_addr = 5'd3; count = 6'd4;
        tick();
        start = 1'b0;
        tick();
        chk("rs_valid", DW'(dout_valid), 1);
        chk("rs_dout", dout, 32'd33);
        #2 rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        tick();
        rst = 1'b0;
        tick();
        chk("rs_busy", DW'(busy), 0);
        chk("rs_valid_lo", DW'(dout_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
